// File: rtl/bf_state_counter_if.sv
// Loop interface between next_state_generator (master) and bf_state_counter (slave):
// next-state/counter commands outward, registered state/counter/kickback flag back.
interface bf_state_counter_if #(
    parameter int CNT_W = 5
);
    logic [2:0]       main_state_n;
    logic [CNT_W-1:0] counter_load;
    logic             counter_load_en;
    logic [1:0]       count_state;
    logic [2:0]       main_state;
    logic [CNT_W-1:0] counter;
    logic             kickback_match;

    modport master (
        output main_state_n, counter_load, counter_load_en, count_state,
        input  main_state, counter, kickback_match
    );

    modport slave (
        input  main_state_n, counter_load, counter_load_en, count_state,
        output main_state, counter, kickback_match
    );
endinterface

// File: rtl/bf_state_counter.sv
// Bound-flasher datapath: main-state register, saturating lamp counter, blink phase, lamp bar.
// Define BF_FLICK_SYNC_EN to pass flick through a 2-flop synchronizer before use.
module bf_state_counter #(
    parameter int LAMP_NUM = 16,
    parameter int CNT_W    = 5,
    parameter int KICK_A   = 5,
    parameter int KICK_B   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flick,
    output logic                flick_q,
    output logic [LAMP_NUM-1:0] lamp,
    bf_state_counter_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP_A   = 3'd1,
        DOWN_A = 3'd2,
        UP_B   = 3'd3,
        DOWN_B = 3'd4,
        UP_C   = 3'd5,
        DOWN_C = 3'd6,
        BLINK  = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] LAMP_MAX = CNT_W'(LAMP_NUM);
    localparam logic [CNT_W-1:0] KICK_A_C = CNT_W'(KICK_A);
    localparam logic [CNT_W-1:0] KICK_B_C = CNT_W'(KICK_B);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              main_state_q, main_state_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic                blink_ph_q, blink_ph_d;
    logic [LAMP_NUM-1:0] lamp_q, lamp_d;

`ifdef BF_FLICK_SYNC_EN
    logic flick_s1_q, flick_s2_q;

    // Two-stage synchronizer for the asynchronous board flick input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flick_s1_q <= 1'b0;
            flick_s2_q <= 1'b0;
        end else begin
            flick_s1_q <= flick;
            flick_s2_q <= flick_s1_q;
        end
    end

    assign flick_q = flick_s2_q;
`else
    assign flick_q = flick;
`endif

    // Next-state, counter, blink phase and lamp bar from the generator's commands
    always_comb begin
        main_state_d = state_e'(bus.main_state_n);
        counter_d    = counter_q;
        blink_ph_d   = 1'b0;
        lamp_d       = '0;

        if (bus.counter_load_en) begin
            if (bus.counter_load > LAMP_MAX) begin
                counter_d = LAMP_MAX;
            end else begin
                counter_d = bus.counter_load;
            end
        end else begin
            case (bus.count_state)
                2'b01: begin
                    if (counter_q < LAMP_MAX) begin
                        counter_d = counter_q + CNT_ONE;
                    end else begin
                        counter_d = counter_q;
                    end
                end
                2'b10: begin
                    if (counter_q > CNT_ZERO) begin
                        counter_d = counter_q - CNT_ONE;
                    end else begin
                        counter_d = counter_q;
                    end
                end
                default: counter_d = counter_q;
            endcase
        end

        // Phase is aligned with main_state: first BLINK cycle sees phase 1
        if (main_state_d == BLINK) begin
            blink_ph_d = ~blink_ph_q;
            lamp_d     = {LAMP_NUM{blink_ph_d}};
        end else begin
            blink_ph_d = 1'b0;
            for (int i = 0; i < LAMP_NUM; i++) begin
                lamp_d[i] = (CNT_W'(i) < counter_d);
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_state_q <= IDLE;
            counter_q    <= '0;
            blink_ph_q   <= 1'b0;
            lamp_q       <= '0;
        end else begin
            main_state_q <= main_state_d;
            counter_q    <= counter_d;
            blink_ph_q   <= blink_ph_d;
            lamp_q       <= lamp_d;
        end
    end

    assign bus.main_state     = main_state_q;
    assign bus.counter        = counter_q;
    assign lamp               = lamp_q;
    assign bus.kickback_match = flick_q &
                                (((main_state_q == UP_B) && (counter_q == KICK_A_C)) ||
                                 ((main_state_q == UP_C) && (counter_q == KICK_B_C)));
endmodule

// File: tb/tb_bf_state_counter.sv
// Directed bench for bf_state_counter: scoreboard of expected state/counter/lamp per cycle,
// plus direct checks of reset, kickback_match and flick_q.
module tb_bf_state_counter;
    logic        clk;
    logic        rst;
    logic        flick;
    logic        flick_q;
    logic [15:0] lamp;

    bf_state_counter_if #(.CNT_W(5)) bus ();

    bf_state_counter dut (
        .clk     (clk),
        .rst     (rst),
        .flick   (flick),
        .flick_q (flick_q),
        .lamp    (lamp),
        .bus     (bus)
    );

    typedef struct {
        string       tag;
        logic [2:0]  ms;
        logic [4:0]  cnt;
        logic [15:0] lamp;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    logic [2:0] m_ms;
    logic [4:0] m_cnt;
    logic       m_ph;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model_lamp(input logic [2:0] ms, input logic [4:0] cnt,
                                               input logic ph);
        logic [16:0] t;
        if (ms == 3'd7) begin
            return {16{ph}};
        end
        t = (17'h1 << cnt) - 17'h1;
        return t[15:0];
    endfunction

    task automatic model_reset();
        m_ms  = 3'd0;
        m_cnt = 5'd0;
        m_ph  = 1'b0;
    endtask

    // Drive one cycle of commands, push the expectation, pop and compare after the edge
    task automatic step(input string tag, input logic [2:0] ms_n, input logic [4:0] ld,
                        input logic ld_en, input logic [1:0] cs);
        exp_t e;
        @(negedge clk);
        bus.main_state_n    = ms_n;
        bus.counter_load    = ld;
        bus.counter_load_en = ld_en;
        bus.count_state     = cs;
        if (ld_en) m_cnt = (ld > 5'd16) ? 5'd16 : ld;
        else if (cs == 2'b01 && m_cnt < 5'd16) m_cnt = m_cnt + 5'd1;
        else if (cs == 2'b10 && m_cnt > 5'd0) m_cnt = m_cnt - 5'd1;
        m_ph = (ms_n == 3'd7) ? ~m_ph : 1'b0;
        m_ms = ms_n;
        e.tag = tag; e.ms = m_ms; e.cnt = m_cnt; e.lamp = model_lamp(m_ms, m_cnt, m_ph);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_state"}, {29'd0, bus.main_state}, {29'd0, e.ms});
            chk({e.tag, "_cnt"},   {27'd0, bus.counter},    {27'd0, e.cnt});
            chk({e.tag, "_lamp"},  {16'd0, lamp},           {16'd0, e.lamp});
        end
    endtask

    // Let flick settle through the synchronizer when it is present
    task automatic flick_settle(input logic [2:0] ms_n);
`ifdef BF_FLICK_SYNC_EN
        step("sync_a", ms_n, 5'd0, 1'b0, 2'b00);
        step("sync_b", ms_n, 5'd0, 1'b0, 2'b00);
`else
        #1;
`endif
    endtask

    initial begin
        rst = 1'b1; flick = 1'b0;
        bus.main_state_n = 3'd0; bus.counter_load = 5'd0;
        bus.counter_load_en = 1'b0; bus.count_state = 2'b00;
        model_reset();
        #12;
        chk("rst_state", {29'd0, bus.main_state}, 32'd0);
        chk("rst_cnt",   {27'd0, bus.counter},    32'd0);
        chk("rst_lamp",  {16'd0, lamp},           32'd0);
        chk("rst_kick",  {31'd0, bus.kickback_match}, 32'd0);
        chk("rst_flickq", {31'd0, flick_q}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Saturating up then down
        for (int i = 0; i < 20; i++) step("up", 3'd1, 5'd0, 1'b0, 2'b01);
        chk("up_full_lamp", {16'd0, lamp}, 32'h0000_FFFF);
        for (int i = 0; i < 20; i++) step("down", 3'd2, 5'd0, 1'b0, 2'b10);
        chk("down_empty_lamp", {16'd0, lamp}, 32'd0);

        // Load beats count; oversize load clamps
        step("load9", 3'd1, 5'd9, 1'b1, 2'b01);
        chk("load9_lamp", {16'd0, lamp}, 32'h0000_01FF);
        step("load20", 3'd1, 5'd20, 1'b1, 2'b01);
        chk("load20_cnt", {27'd0, bus.counter}, 32'd16);
        step("hold11", 3'd1, 5'd0, 1'b0, 2'b11);

        // Kickback
        step("upb5", 3'd3, 5'd5, 1'b1, 2'b00);
        @(negedge clk);
        flick = 1'b1;
        flick_settle(3'd3);
        chk("kick_upb5", {31'd0, bus.kickback_match}, 32'd1);
        chk("flickq_hi", {31'd0, flick_q}, 32'd1);
        step("upb6", 3'd3, 5'd6, 1'b1, 2'b00);
        chk("kick_upb6", {31'd0, bus.kickback_match}, 32'd0);
        step("upa5", 3'd1, 5'd5, 1'b1, 2'b00);
        chk("kick_upa5", {31'd0, bus.kickback_match}, 32'd0);
        step("upc10", 3'd5, 5'd10, 1'b1, 2'b00);
        chk("kick_upc10", {31'd0, bus.kickback_match}, 32'd1);
        step("upb5b", 3'd3, 5'd5, 1'b1, 2'b00);
        chk("kick_upb5b", {31'd0, bus.kickback_match}, 32'd1);
        @(negedge clk);
        flick = 1'b0;
        flick_settle(3'd3);
        chk("kick_noflick", {31'd0, bus.kickback_match}, 32'd0);

        // Asynchronous reset mid-count
        step("upb7", 3'd3, 5'd7, 1'b1, 2'b01);
        flick = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mrst_state", {29'd0, bus.main_state}, 32'd0);
        chk("mrst_cnt",   {27'd0, bus.counter},    32'd0);
        chk("mrst_lamp",  {16'd0, lamp},           32'd0);
        chk("mrst_kick",  {31'd0, bus.kickback_match}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        flick = 1'b0;

        // Blink then exit to thermometer of counter 3
        step("load3", 3'd0, 5'd3, 1'b1, 2'b00);
        for (int i = 0; i < 6; i++) begin
            step("blink", 3'd7, 5'd0, 1'b0, 2'b00);
            chk("blink_lamp", {16'd0, lamp}, (i % 2 == 0) ? 32'h0000_FFFF : 32'd0);
        end
        step("exit", 3'd0, 5'd0, 1'b0, 2'b00);
        chk("exit_lamp", {16'd0, lamp}, 32'h0000_0007);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
